// File: rtl/imm_pkg.sv
// Shared constants for the immediate compressor: field widths, beat kind
// encodings and FSM state encodings.
package imm_pkg;

  localparam int WORD_W = 16;
  localparam int IMM_W  = 7;
  localparam int HI_W   = WORD_W - IMM_W;

  localparam logic [1:0] KIND_SHORT = 2'd0;
  localparam logic [1:0] KIND_HIGH  = 2'd1;
  localparam logic [1:0] KIND_LOW   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } stateT;

endpackage

// File: rtl/imm_compress_fit_check.sv
// imm_fit_check: decides whether a constant is sign-representable in the
// immediate field and slices out the candidate beat payloads.
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [WORD_W-1:0] inData,
  output logic              fits,
  output logic [HI_W-1:0]   hiField,
  output logic [HI_W-1:0]   loField,
  output logic [HI_W-1:0]   shortField
);

  // Bits [WORD_W-1:IMM_W-1] must all match the immediate sign bit.
  logic [WORD_W-IMM_W:0] signBits;

  assign signBits   = inData[WORD_W-1:IMM_W-1];
  assign fits       = (&signBits) | ~(|signBits);
  assign hiField    = inData[WORD_W-1:IMM_W];
  assign loField    = {{(HI_W-IMM_W){1'b0}}, inData[IMM_W-1:0]};
  assign shortField = {{(HI_W-IMM_W){inData[IMM_W-1]}}, inData[IMM_W-1:0]};

endmodule

// File: rtl/imm_compress.sv
// imm_compress: narrows WORD_W-bit constants into IMM_W-bit immediate beats.
// A constant that fits becomes one SHORT beat; otherwise a HIGH beat
// (upper bits) followed by a LOW beat (lower bits).
// Optional macro IMM_COMPRESS_STATS_EN adds saturating beat counters.
//
// state  | meaning
// IDLE   | no beat pending, ready for a constant
// SHORT  | presenting a single sign-extended immediate beat
// HIGH   | presenting the upper-load beat; LOW still owed
// LOW    | presenting the or-immediate beat that ends a pair
module imm_compress
  import imm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [HI_W-1:0]   out_data,
  output logic              out_last
`ifdef IMM_COMPRESS_STATS_EN
  ,
  output logic [15:0]       stat_short,
  output logic [15:0]       stat_long
`endif
);

  stateT             state, stateNext;
  logic [IMM_W-1:0]  heldLow, heldLowNext;
  logic [1:0]        kindQ, kindNext;
  logic [HI_W-1:0]   dataQ, dataNext;
  logic              lastQ, lastNext;
  logic              accept;
  logic              fits;
  logic [HI_W-1:0]   hiField, loField, shortField;

  imm_fit_check uFit (
    .inData     (in_data),
    .fits       (fits),
    .hiField    (hiField),
    .loField    (loField),
    .shortField (shortField)
  );

  // A new constant can enter when idle or as the final beat of the current
  // constant is taken, which gives bubble-free streaming.
  assign in_ready  = (state == ST_IDLE) |
                     (((state == ST_SHORT) | (state == ST_LOW)) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state != ST_IDLE);
  assign out_kind  = kindQ;
  assign out_data  = dataQ;
  assign out_last  = lastQ;

  // State, held low field and output beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      heldLow <= '0;
      kindQ   <= KIND_SHORT;
      dataQ   <= '0;
      lastQ   <= 1'b0;
    end else begin
      state   <= stateNext;
      heldLow <= heldLowNext;
      kindQ   <= kindNext;
      dataQ   <= dataNext;
      lastQ   <= lastNext;
    end
  end

  // Next state and next beat contents.
  always_comb begin
    stateNext   = state;
    heldLowNext = heldLow;
    kindNext    = kindQ;
    dataNext    = dataQ;
    lastNext    = lastQ;
    if (state == ST_HIGH) begin
      if (out_ready) begin
        stateNext = ST_LOW;
        kindNext  = KIND_LOW;
        dataNext  = {{(HI_W-IMM_W){1'b0}}, heldLow};
        lastNext  = 1'b1;
      end
    end else if (accept) begin
      // Only the low field is needed after the HIGH beat is built.
      heldLowNext = loField[IMM_W-1:0];
      if (fits) begin
        stateNext = ST_SHORT;
        kindNext  = KIND_SHORT;
        dataNext  = shortField;
        lastNext  = 1'b1;
      end else begin
        stateNext = ST_HIGH;
        kindNext  = KIND_HIGH;
        dataNext  = hiField;
        lastNext  = 1'b0;
      end
    end else if ((state != ST_IDLE) && out_ready) begin
      stateNext = ST_IDLE;
      kindNext  = KIND_SHORT;
      dataNext  = '0;
      lastNext  = 1'b0;
    end
  end

`ifdef IMM_COMPRESS_STATS_EN
  logic shortDone, longDone;

  assign shortDone = (state == ST_SHORT) & out_ready;
  assign longDone  = (state == ST_LOW) & out_ready;

  // Saturating counts of completed SHORT beats and completed HIGH/LOW pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_short <= '0;
      stat_long  <= '0;
    end else begin
      if (shortDone && (stat_short != 16'hFFFF)) stat_short <= stat_short + 16'd1;
      if (longDone && (stat_long != 16'hFFFF))   stat_long  <= stat_long + 16'd1;
    end
  end
`endif

endmodule
